// File: rtl/lab_2_sweep_ctrl_if.sv
// Link between the sweep sequencer and the lab-2 logic unit under test.
// The sequencer drives the a/b/c stimulus and reads back the x/y response.
interface lab_2_sweep_ctrl_if;
   logic a_o;
   logic b_o;
   logic c_o;
   logic x_i;
   logic y_i;

   modport master (output a_o, output b_o, output c_o, input x_i, input y_i);
   modport slave  (input a_o, input b_o, input c_o, output x_i, output y_i);
endinterface

// File: rtl/lab_2_sweep_ctrl.sv
// Self-test sequencer for the lab-2 logic unit (x = ~c ^ (a|b), y = a & b).
// Walks all eight {a,b,c} vectors in ascending order. Each vector is held for
// SETTLE_CYCLES cycles, then the response is sampled and compared with a golden
// model. Raw responses, a failure mask and the first failing index are logged.
// A done pulse and a pass flag report the outcome.
// All outputs come straight from registers. The stimulus and busy registers
// follow the next state, so the stimulus stays aligned with the state it
// belongs to. done and pass are loaded while FINISH is current, which puts the
// done pulse 8*(SETTLE_CYCLES+1)+1 cycles after start.
module lab_2_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   lab_2_sweep_ctrl_if.master        lu,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [3:0]                err_count,
   output logic [7:0]                fail_mask,
   output logic                      first_err_valid,
   output logic [2:0]                first_err_vec,
   output logic [15:0]               resp_log
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

   localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

   // Reference behaviour of the logic unit for vector {a,b,c}; returns {x,y}.
   function automatic logic [1:0] golden(input logic [2:0] vec);
      logic a, b, c;
      a = vec[2];
      b = vec[1];
      c = vec[0];
      return {~(c ^ (a | b)), a & b};
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  vec_q, vec_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  abc_q, abc_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [3:0]  err_q, err_d;
   logic [7:0]  mask_q, mask_d;
   logic        fev_q, fev_d;
   logic [2:0]  fevec_q, fevec_d;
   logic [15:0] log_q, log_d;
   logic [1:0]  resp;

   assign resp = {lu.x_i, lu.y_i};

   // State and result registers; reset clears everything to zero / IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         abc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         mask_q  <= '0;
         fev_q   <= 1'b0;
         fevec_q <= '0;
         log_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         abc_q   <= abc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         fev_q   <= fev_d;
         fevec_q <= fevec_d;
         log_q   <= log_d;
      end
   end

   // Next-state and result-update logic for the sweep FSM.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      abc_d   = abc_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      mask_d  = mask_q;
      fev_d   = fev_q;
      fevec_d = fevec_q;
      log_d   = log_q;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            abc_d  = 3'b000;
            if (start) begin
               err_d   = '0;
               mask_d  = '0;
               log_d   = '0;
               fev_d   = 1'b0;
               fevec_d = '0;
               pass_d  = 1'b0;
               vec_d   = 3'd0;
               cnt_d   = RELOAD;
               abc_d   = 3'd0;
               busy_d  = 1'b1;
               state_d = SETTLE;
            end
         end

         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
               abc_d   = 3'b000;
               busy_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (cnt_q == 4'd0) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         SAMPLE: begin
            if (abort) begin
               // The sample taken in this cycle is dropped.
               state_d = IDLE;
               abc_d   = 3'b000;
               busy_d  = 1'b0;
               pass_d  = 1'b0;
            end else begin
               log_d[{vec_q, 1'b0} +: 2] = resp;
               if (resp !== golden(vec_q)) begin
                  mask_d[vec_q] = 1'b1;
                  err_d         = err_q + 4'd1;
                  if (!fev_q) begin
                     fev_d   = 1'b1;
                     fevec_d = vec_q;
                  end
               end
               if (vec_q == 3'd7) begin
                  state_d = FINISH;
                  abc_d   = 3'b000;
                  busy_d  = 1'b0;
               end else begin
                  vec_d   = vec_q + 3'd1;
                  abc_d   = vec_q + 3'd1;
                  cnt_d   = RELOAD;
                  state_d = SETTLE;
               end
            end
         end

         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_q == 4'd0);
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            abc_d   = 3'b000;
         end
      endcase
   end

   assign lu.a_o          = abc_q[2];
   assign lu.b_o          = abc_q[1];
   assign lu.c_o          = abc_q[0];
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign fail_mask       = mask_q;
   assign first_err_valid = fev_q;
   assign first_err_vec   = fevec_q;
   assign resp_log        = log_q;

endmodule
